reg_pipe_vr: RTL and testbench



---
 rtl/reg_pipe_vr.sv | 105 ++++++++++
 tb/tb_reg_pipe_vr.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe_vr.sv
// rtl/reg_pipe_vr.sv - parametrised valid/ready register pipeline with flush and occupancy count
module reg_pipe_vr #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_adv;
  logic [DEPTH-1:0] rdy;
  logic             in_xfer;
  logic             out_xfer;

  // Readiness ripples back from the output: a stage can load if it is empty or its successor moves.
  always_comb begin : rdy_chain
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain  = !v[k] | chain;
      rdy[k] = chain;
    end
  end

  // Next valid bits: ready stages take their predecessor's valid, stalled stages hold.
  always_comb begin
    v_adv = v;
    if (rdy[0]) begin
      v_adv[0] = in_valid & !flush;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_adv[k] = v[k-1];
      end
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v[DEPTH-1] & out_ready;

  // Data registers shift on readiness and freeze during flush; invalid stages carry stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
    end else if (!flush) begin
      if (rdy[0]) begin
        data_q[0] <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  // Valid bits: flush empties every stage, otherwise advance or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v <= v_adv;
    end
  end

  // Occupancy tracks accepted minus delivered words; flush and reset clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  // Occupancy must always agree with the valid bits and stay within the pipeline depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(count) == $countones(v) && int'(count) <= DEPTH);
    end
  end

endmodule

// File: tb/tb_reg_pipe_vr.sv
// tb/tb_reg_pipe_vr.sv - scoreboard bench for reg_pipe_vr at three parameter points
module tb_reg_pipe_vr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: WIDTH=8, DEPTH=4, RESET_VAL=0xA5
  logic       a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_count;
  logic [7:0] aq [$];

  // DUT B: WIDTH=1, DEPTH=1
  logic       b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0] b_in_data, b_out_data;
  logic [0:0] b_count;
  logic [0:0] bq [$];

  // DUT C: WIDTH=33, DEPTH=7
  logic        c_reset, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [32:0] c_in_data, c_out_data;
  logic [2:0]  c_count;
  logic [32:0] cq [$];

  reg_pipe_vr #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut_a (
    .clk(clk), .reset(a_reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count));

  reg_pipe_vr #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count));

  reg_pipe_vr #(.WIDTH(33), .DEPTH(7), .RESET_VAL(33'h0)) dut_c (
    .clk(clk), .reset(c_reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every completed output transfer is compared with the oldest expected word.
  always @(negedge clk) begin
    if (!a_reset && a_out_valid && a_out_ready) begin
      if (aq.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_out: got %0h expected no transfer", a_out_data);
      end else begin
        check("a_out_data", a_out_data, aq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!b_reset && b_out_valid && b_out_ready) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_out: got %0h expected no transfer", b_out_data);
      end else begin
        check("b_out_data", b_out_data, bq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!c_reset && c_out_valid && c_out_ready) begin
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected_out: got %0h expected no transfer", c_out_data);
      end else begin
        check("c_out_data", c_out_data, cq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] w;
    a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 8'hFF; a_out_ready = 1'b0;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 1'b0; b_out_ready = 1'b0;
    c_reset = 1'b1; c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0;  c_out_ready = 1'b0;

    // ---------------- DUT A: reset with input offered
    for (int i = 0; i < 2; i++) begin
      next();
      check("a_rst_out_valid", a_out_valid, 0);
      check("a_rst_out_data", a_out_data, 8'hA5);
      check("a_rst_count", a_count, 0);
      check("a_rst_in_ready", a_in_ready, 1);
    end
    a_reset = 1'b0; a_in_valid = 1'b0;
    next();
    check("a_post_rst_count", a_count, 0);
    check("a_post_rst_out_valid", a_out_valid, 0);
    check("a_post_rst_out_data", a_out_data, 8'hA5);

    // ---------------- DUT A: streaming 0x01..0x08
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(i);
      aq.push_back(8'(i));
      #1;
      check("a_stream_in_ready", a_in_ready, 1);
      check("a_stream_count", a_count, (i - 1 < 4) ? i - 1 : 4);
      if (i == 4) check("a_latency_not_yet", a_out_valid, 0);
      if (i == 5) begin
        check("a_latency_valid", a_out_valid, 1);
        check("a_latency_data", a_out_data, 8'h01);
      end
      next();
    end
    a_in_valid = 1'b0;
    for (int n = 0; n < 12 && aq.size() != 0; n++) next();
    check("a_stream_drained", aq.size(), 0);
    check("a_stream_end_count", a_count, 0);
    check("a_stream_end_valid", a_out_valid, 0);

    // ---------------- DUT A: back-pressure and collapse
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(8'h10 + i);
      if (i < 4) aq.push_back(8'(8'h10 + i));
      #1;
      check("a_bp_in_ready", a_in_ready, (i < 4) ? 1 : 0);
      next();
    end
    check("a_bp_full_count", a_count, 4);
    check("a_bp_full_valid", a_out_valid, 1);
    check("a_bp_full_data", a_out_data, 8'h10);
    a_out_ready = 1'b1;
    aq.push_back(8'h14);
    #1;
    check("a_bp_full_drain_in_ready", a_in_ready, 1);
    next();
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    #1;
    check("a_bp_shift_count", a_count, 4);
    check("a_bp_shift_data", a_out_data, 8'h11);
    a_out_ready = 1'b1;
    for (int n = 0; n < 12 && aq.size() != 0; n++) next();
    check("a_bp_drained", aq.size(), 0);
    check("a_bp_end_count", a_count, 0);

    // ---------------- DUT A: bubbles collapse
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h20; aq.push_back(8'h20);
    next();
    a_in_valid = 1'b0;
    next();
    next();
    a_in_valid = 1'b1; a_in_data = 8'h21; aq.push_back(8'h21);
    next();
    a_in_valid = 1'b0;
    next();
    next();
    next();
    check("a_bub_count", a_count, 2);
    check("a_bub_data", a_out_data, 8'h20);
    a_out_ready = 1'b1;
    #1;
    check("a_bub_first_valid", a_out_valid, 1);
    next();
    check("a_bub_second_valid", a_out_valid, 1);
    next();
    check("a_bub_end_valid", a_out_valid, 0);
    check("a_bub_end_count", a_count, 0);
    check("a_bub_drained", aq.size(), 0);

    // ---------------- DUT A: flush while offering 0x34
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(8'h30 + i);
      aq.push_back(8'(8'h30 + i));
      next();
    end
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h34;
    aq.delete();
    #1;
    check("a_flush_in_ready", a_in_ready, 0);
    next();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    check("a_flush_count", a_count, 0);
    check("a_flush_valid", a_out_valid, 0);
    check("a_flush_data", a_out_data, 8'h30);
    a_out_ready = 1'b1;
    next();
    next();
    next();
    check("a_flush_nothing_valid", a_out_valid, 0);
    check("a_flush_nothing_count", a_count, 0);

    // ---------------- DUT A: reset mid-stream with a word at the output
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h40; aq.push_back(8'h40);
    next();
    a_in_data = 8'h41; aq.push_back(8'h41);
    next();
    a_in_valid = 1'b0;
    next();
    next();
    check("a_mid_pre_valid", a_out_valid, 1);
    a_reset = 1'b1; a_out_ready = 1'b1;
    aq.delete();
    next();
    a_reset = 1'b0;
    #1;
    check("a_mid_rst_valid", a_out_valid, 0);
    check("a_mid_rst_count", a_count, 0);
    check("a_mid_rst_data", a_out_data, 8'hA5);

    // ---------------- DUT B: DEPTH=1, WIDTH=1
    next();
    b_reset = 1'b0;
    #1;
    check("b_rst_valid", b_out_valid, 0);
    check("b_rst_count", b_count, 0);
    check("b_rst_data", b_out_data, 0);
    b_in_valid = 1'b1; b_in_data = 1'b1; bq.push_back(1'b1);
    #1;
    check("b_empty_in_ready", b_in_ready, 1);
    next();
    b_in_data = 1'b0;
    #1;
    check("b_latency_valid", b_out_valid, 1);
    check("b_full_count", b_count, 1);
    check("b_full_in_ready", b_in_ready, 0);
    next();
    check("b_hold_valid", b_out_valid, 1);
    check("b_hold_data", b_out_data, 1);
    b_out_ready = 1'b1; bq.push_back(1'b0);
    #1;
    check("b_full_drain_in_ready", b_in_ready, 1);
    next();
    b_in_valid = 1'b0;
    #1;
    check("b_shift_count", b_count, 1);
    check("b_shift_valid", b_out_valid, 1);
    next();
    check("b_end_valid", b_out_valid, 0);
    check("b_end_count", b_count, 0);
    check("b_drained", bq.size(), 0);

    // ---------------- DUT C: DEPTH=7, WIDTH=33 streaming
    c_reset = 1'b0;
    #1;
    check("c_rst_valid", c_out_valid, 0);
    check("c_rst_count", c_count, 0);
    c_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = {i[0], 32'hA5A5_0000 + 32'(i)};
      c_in_valid = 1'b1; c_in_data = w; cq.push_back(w);
      #1;
      check("c_stream_in_ready", c_in_ready, 1);
      if (i == 6) check("c_latency_not_yet", c_out_valid, 0);
      if (i == 7) begin
        check("c_latency_valid", c_out_valid, 1);
        check("c_latency_data", c_out_data, 33'h0_A5A5_0000);
      end
      next();
    end
    c_in_valid = 1'b0;
    for (int n = 0; n < 20 && cq.size() != 0; n++) next();
    check("c_stream_drained", cq.size(), 0);
    check("c_stream_end_count", c_count, 0);

    // ---------------- DUT C: fill to full under stall
    c_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = 33'h1_0000_0000 + 33'(i);
      c_in_valid = 1'b1; c_in_data = w;
      if (i < 7) cq.push_back(w);
      #1;
      check("c_bp_in_ready", c_in_ready, (i < 7) ? 1 : 0);
      next();
    end
    check("c_full_count", c_count, 7);
    check("c_full_valid", c_out_valid, 1);
    check("c_full_data", c_out_data, 33'h1_0000_0000);
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    for (int n = 0; n < 20 && cq.size() != 0; n++) next();
    check("c_bp_drained", cq.size(), 0);
    check("c_bp_end_count", c_count, 0);
    check("c_bp_end_valid", c_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
